// File: rtl/bc_miner.sv
// Double-SHA-256 nonce miner: loads midstate/header tail/target from a block store,
// sweeps nonces 0..2^COUNTBITS-1 at one round per cycle, and pushes every hit to a nonce buffer.
module bc_miner #(
  parameter int DELAY_C   = 129,
  parameter int COUNTBITS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        blk_rd_en,
  output logic [3:0]  blk_rd_addr,
  input  logic [31:0] blk_rd_data,
  output logic        nb_wr_en,
  output logic [31:0] nb_wr_data,
  input  logic        nb_full
);

  typedef enum logic [2:0] {IDLE, LOAD, HASH1, HASH2, CHECK, PAD, WRITE} state_e;

  // A hit spends its WRITE cycle out of the pad budget, so both paths take DELAY_C cycles.
  localparam logic [31:0]          PAD_MISS   = 32'(DELAY_C - 129);
  localparam logic [31:0]          PAD_HIT    = (DELAY_C > 129) ? 32'(DELAY_C - 130) : 32'd0;
  localparam logic                 PAD_HIT_EN = (DELAY_C > 129);
  localparam logic [COUNTBITS-1:0] LAST_NONCE = '1;
  localparam logic [COUNTBITS-1:0] NONCE_ONE  = 1;

  localparam logic [7:0][31:0] IV = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [15:0][31:0] msg1(input logic [2:0][31:0] t, input logic [COUNTBITS-1:0] n);
    logic [15:0][31:0] m;
    m     = '0;
    m[0]  = t[0];
    m[1]  = t[1];
    m[2]  = t[2];
    m[3]  = 32'(n);
    m[4]  = 32'h80000000;
    m[15] = 32'h00000280;
    return m;
  endfunction

  function automatic logic [15:0][31:0] msg2(input logic [7:0][31:0] d);
    logic [15:0][31:0] m;
    m      = '0;
    m[7:0] = d;
    m[8]   = 32'h80000000;
    m[15]  = 32'h00000100;
    return m;
  endfunction

  state_e               state_q, state_d;
  logic [6:0]           cnt_q, cnt_d;
  logic [31:0]          pad_q, pad_d;
  logic [COUNTBITS-1:0] nonce_q, nonce_d;
  logic [7:0][31:0]     mid_q, mid_d;
  logic [2:0][31:0]     tail_q, tail_d;
  logic [31:0]          target_q, target_d;
  logic [15:0][31:0]    w_q, w_d;
  logic [7:0][31:0]     hv_q, hv_d;

  logic [31:0]          t1, t2, h7_final;
  logic [7:0][31:0]     rnd, dig1;
  logic [15:0][31:0]    w_shift;
  logic [6:0]           ld_idx;
  logic                 advance;

  // One compression round plus the 16-word sliding message window.
  always_comb begin
    t1 = hv_q[7] + bsig1(hv_q[4]) + ((hv_q[4] & hv_q[5]) ^ (~hv_q[4] & hv_q[6]))
       + K[cnt_q[5:0]] + w_q[0];
    t2 = bsig0(hv_q[0]) + ((hv_q[0] & hv_q[1]) ^ (hv_q[0] & hv_q[2]) ^ (hv_q[1] & hv_q[2]));
    rnd    = {hv_q[6:4], hv_q[3] + t1, hv_q[2:0], t1 + t2};
    for (int i = 0; i < 8; i++) dig1[i] = rnd[i] + mid_q[i];
    for (int i = 0; i < 15; i++) w_shift[i] = w_q[i+1];
    w_shift[15] = ssig1(w_q[14]) + w_q[9] + ssig0(w_q[1]) + w_q[0];
    // Final H7 equals the pre-round g of round 63, so it is ready in CHECK.
    h7_final = hv_q[6] + IV[7];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pad_d     = pad_q;
    nonce_d   = nonce_q;
    mid_d     = mid_q;
    tail_d    = tail_q;
    target_d  = target_q;
    w_d       = w_q;
    hv_d      = hv_q;
    ld_idx    = cnt_q - 7'd1;
    advance   = 1'b0;
    done      = 1'b0;
    nb_wr_en  = 1'b0;

    case (state_q)
      IDLE: if (start) begin
        state_d = LOAD;
        cnt_d   = 7'd0;
      end
      LOAD: begin
        if (cnt_q != 7'd0) begin
          if (ld_idx < 7'd8)       mid_d[ld_idx[2:0]]  = blk_rd_data;
          else if (ld_idx < 7'd11) tail_d[ld_idx[1:0]] = blk_rd_data;
          else                     target_d            = blk_rd_data;
        end
        cnt_d = cnt_q + 7'd1;
        if (cnt_q == 7'd12) begin
          state_d = HASH1;
          cnt_d   = 7'd0;
          nonce_d = '0;
          hv_d    = mid_q;
          w_d     = msg1(tail_q, '0);
        end
      end
      HASH1: begin
        hv_d  = rnd;
        w_d   = w_shift;
        cnt_d = cnt_q + 7'd1;
        if (cnt_q == 7'd63) begin
          state_d = HASH2;
          cnt_d   = 7'd0;
          hv_d    = IV;
          w_d     = msg2(dig1);
        end
      end
      HASH2: begin
        hv_d  = rnd;
        w_d   = w_shift;
        cnt_d = cnt_q + 7'd1;
        if (cnt_q == 7'd62) state_d = CHECK;
      end
      CHECK: begin
        hv_d    = rnd;
        pad_d   = PAD_MISS;
        state_d = (h7_final <= target_q) ? WRITE : PAD;
      end
      WRITE: if (!nb_full) begin
        nb_wr_en = 1'b1;
        if (PAD_HIT_EN) begin
          state_d = PAD;
          pad_d   = PAD_HIT;
        end else begin
          advance = 1'b1;
        end
      end
      PAD: begin
        if (pad_q == 32'd0) advance = 1'b1;
        else                pad_d   = pad_q - 32'd1;
      end
      default: state_d = IDLE;
    endcase

    if (advance) begin
      if (nonce_q == LAST_NONCE) begin
        done    = 1'b1;
        state_d = IDLE;
      end else begin
        nonce_d = nonce_q + NONCE_ONE;
        state_d = HASH1;
        cnt_d   = 7'd0;
        hv_d    = mid_q;
        w_d     = msg1(tail_q, nonce_q + NONCE_ONE);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      pad_q    <= '0;
      nonce_q  <= '0;
      mid_q    <= '0;
      tail_q   <= '0;
      target_q <= '0;
      w_q      <= '0;
      hv_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pad_q    <= pad_d;
      nonce_q  <= nonce_d;
      mid_q    <= mid_d;
      tail_q   <= tail_d;
      target_q <= target_d;
      w_q      <= w_d;
      hv_q     <= hv_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign blk_rd_en   = (state_q == LOAD) && (cnt_q < 7'd12);
  assign blk_rd_addr = blk_rd_en ? cnt_q[3:0] : 4'd0;
  assign nb_wr_data  = (state_q == WRITE) ? 32'(nonce_q) : 32'd0;

endmodule

// File: tb/tb_bc_miner.sv
// Directed-random bench for bc_miner: a software double-SHA-256 model predicts which
// nonces are written and when each write and the done pulse occur.
module tb_bc_miner;
  localparam int D  = 129;
  localparam int CB = 4;
  localparam int NN = 16;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, nb_full = 1'b0;
  logic        busy, done, blk_rd_en, nb_wr_en;
  logic [3:0]  blk_rd_addr;
  logic [31:0] blk_rd_data = '0, nb_wr_data;

  always #5 clk = ~clk;

  bc_miner #(.DELAY_C(D), .COUNTBITS(CB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .blk_rd_en(blk_rd_en), .blk_rd_addr(blk_rd_addr), .blk_rd_data(blk_rd_data),
    .nb_wr_en(nb_wr_en), .nb_wr_data(nb_wr_data), .nb_full(nb_full));

  localparam logic [7:0][31:0] IV = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};
  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  logic [31:0] mem [16];
  always @(posedge clk) if (blk_rd_en) blk_rd_data <= mem[blk_rd_addr];

  int edge_cnt = 0;
  int t0 = 0;
  int rd_cnt = 0;
  int vectors = 0;
  int miscompares = 0;
  int wr_nonce[$];
  int wr_time[$];
  int done_time[$];

  always @(posedge clk) edge_cnt++;

  // Cycle index k: start is high in cycle 0, the first LOAD cycle is cycle 1.
  always @(negedge clk) begin
    if (nb_wr_en) begin
      wr_nonce.push_back(int'(nb_wr_data));
      wr_time.push_back(edge_cnt - t0 + 1);
    end
    if (done) done_time.push_back(edge_cnt - t0 + 1);
    if (blk_rd_en) rd_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [7:0][31:0] compress(input logic [7:0][31:0] hin, input logic [15:0][31:0] m);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] s0, s1, ch, mj, tt1, tt2;
    logic [7:0][31:0] r;
    for (int t = 0; t < 16; t++) w[t] = m[t];
    for (int t = 16; t < 64; t++)
      w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
           + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    for (int i = 0; i < 8; i++) v[i] = hin[i];
    for (int t = 0; t < 64; t++) begin
      s1  = rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25);
      ch  = (v[4] & v[5]) ^ (~v[4] & v[6]);
      tt1 = v[7] + s1 + ch + KT[t] + w[t];
      s0  = rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22);
      mj  = (v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]);
      tt2 = s0 + mj;
      for (int i = 7; i > 0; i--) v[i] = v[i-1];
      v[4] = v[4] + tt1;
      v[0] = tt1 + tt2;
    end
    for (int i = 0; i < 8; i++) r[i] = hin[i] + v[i];
    return r;
  endfunction

  function automatic logic [31:0] model_h7(input int n);
    logic [7:0][31:0]  mid, d1, d2;
    logic [15:0][31:0] b;
    for (int i = 0; i < 8; i++) mid[i] = mem[i];
    b = '0;
    b[0] = mem[8]; b[1] = mem[9]; b[2] = mem[10];
    b[3] = 32'(n); b[4] = 32'h80000000; b[15] = 32'd640;
    d1 = compress(mid, b);
    b = '0;
    for (int i = 0; i < 8; i++) b[i] = d1[i];
    b[8] = 32'h80000000; b[15] = 32'd256;
    d2 = compress(IV, b);
    return d2[7];
  endfunction

  task automatic pulse_start();
    wr_nonce.delete(); wr_time.delete(); done_time.delete(); rd_cnt = 0;
    start = 1'b1;
    @(posedge clk); #1;
    t0 = edge_cnt;
    start = 1'b0;
  endtask

  // Full search; stall_len holds nb_full from the first hit's slot, restart_k re-pulses start.
  task automatic run(input string name, input logic [31:0] tgt, input int stall_len, input int restart_k);
    int exp_n[$];
    int exp_t[$];
    int first_hit;
    int s0;
    int k;
    int n;
    int stall;
    first_hit = -1;
    mem[11] = tgt;
    for (int i = 0; i < NN; i++)
      if (model_h7(i) <= tgt) begin
        if (first_hit < 0) first_hit = i;
        exp_n.push_back(i);
      end
    stall = (first_hit >= 0) ? stall_len : 0;
    s0 = 13 + D * (first_hit + 1);
    foreach (exp_n[i]) exp_t.push_back(13 + D * (exp_n[i] + 1) + stall);
    pulse_start();
    n = 0;
    while (done_time.size() == 0 && n < 4000) begin
      k = edge_cnt - t0 + 1;
      nb_full = (first_hit >= 0) && (k >= s0) && (k < s0 + stall_len);
      start = (k == restart_k);
      if (k == 1) chk({name, "_busy_k1"}, 64'(busy), 64'd1);
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    nb_full = 1'b0;
    chk({name, "_done_time"}, 64'(done_time.size() > 0 ? done_time[0] : -1), 64'(13 + NN * D + stall));
    chk({name, "_busy_after"}, 64'(busy), 64'd0);
    chk({name, "_rd_count"}, 64'(rd_cnt), 64'd12);
    chk({name, "_wr_count"}, 64'(wr_nonce.size()), 64'(exp_n.size()));
    for (int i = 0; i < exp_n.size() && i < wr_nonce.size(); i++) begin
      chk({name, "_wr_nonce"}, 64'(wr_nonce[i]), 64'(exp_n[i]));
      chk({name, "_wr_time"}, 64'(wr_time[i]), 64'(exp_t[i]));
    end
    repeat (3) @(posedge clk);
    #1;
    chk({name, "_single_done"}, 64'(done_time.size()), 64'd1);
  endtask

  task automatic rand_header();
    for (int i = 0; i < 11; i++) mem[i] = $urandom;
    for (int i = 11; i < 16; i++) mem[i] = '0;
  endtask

  initial begin
    logic [15:0][31:0] abc;
    logic [7:0][31:0]  dg;
    int pre_wr;
    int exp_pre;

    abc = '0; abc[0] = 32'h61626380; abc[15] = 32'h18;
    dg = compress(IV, abc);
    chk("model_abc_h0", 64'(dg[0]), 64'h00000000ba7816bf);
    chk("model_abc_h7", 64'(dg[7]), 64'h00000000f20015ad);

    rand_header();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", 64'({busy, done, blk_rd_en, blk_rd_addr, nb_wr_en, nb_wr_data}), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run("all_hit", 32'hFFFFFFFF, 0, 0);
    rand_header();
    run("zero_tgt", 32'h00000000, 0, 0);
    rand_header();
    run("rand_tgt1", $urandom, 0, 0);
    rand_header();
    run("rand_tgt2", $urandom, 0, 0);
    rand_header();
    run("stall50", 32'hFFFFFFFF, 50, 0);
    rand_header();
    run("restart", 32'hFFFFFFFF, 0, 300);

    rand_header();
    mem[11] = 32'hFFFFFFFF;
    pulse_start();
    while (edge_cnt - t0 + 1 < 500) begin @(posedge clk); #1; end
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_outs", 64'({busy, done, blk_rd_en, blk_rd_addr, nb_wr_en, nb_wr_data}), 64'd0);
    exp_pre = 0;
    for (int i = 0; i < NN; i++) if (13 + D * (i + 1) < 500) exp_pre++;
    pre_wr = wr_nonce.size();
    chk("midrst_pre_writes", 64'(pre_wr), 64'(exp_pre));
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2500) @(posedge clk);
    #1;
    chk("midrst_no_writes", 64'(wr_nonce.size()), 64'(pre_wr));
    chk("midrst_no_done", 64'(done_time.size()), 64'd0);
    chk("midrst_idle", 64'(busy), 64'd0);
    run("after_rst", 32'hFFFFFFFF, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/bc_miner.md
BC_MINER -- requirements
Module: bc_miner

Interface
REQ-001 Parameter DELAY_C, default 129: clock cycles spent per nonce; values below 129 are illegal.
REQ-002 Parameter COUNTBITS, default 4: nonce counter width; nonces 0 .. 2^COUNTBITS-1 are searched.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  one-cycle pulse that begins a search; ignored while busy.
REQ-006 busy  out  1  high from the cycle after an accepted start until done.
REQ-007 done  out  1  one-cycle pulse when the search finishes.
REQ-008 blk_rd_en  out  1  block-store read strobe.
REQ-009 blk_rd_addr  out  4  block-store word address.
REQ-010 blk_rd_data  in  32  block-store read data, valid one cycle after blk_rd_en.
REQ-011 nb_wr_en  out  1  nonce-buffer write strobe.
REQ-012 nb_wr_data  out  32  winning nonce, zero-extended from COUNTBITS.
REQ-013 nb_full  in  1  nonce buffer cannot accept a write.

Function
REQ-014 States are IDLE, LOAD, HASH1, HASH2, CHECK, PAD and WRITE.
REQ-015 IDLE -> LOAD on start; LOAD reads addresses 0..11 on consecutive cycles, then waits one latency cycle (13 cycles in total).
- Words 0-7: midstate H0..H7.
- Words 8-10: header tail T0..T2.
- Word 11: target.
REQ-016 HASH1: 64 SHA-256 rounds, one round per cycle, from the midstate with message block W0..W2=T0..T2, W3=nonce, W4=0x80000000, W5..W14=0, W15=0x00000280; the digest is the feed-forward sum with the midstate.
REQ-017 HASH2: 64 rounds from the SHA-256 IV (0x6a09e667 .. 0x5be0cd19) with block W0..W7=HASH1 digest, W8=0x80000000, W9..W14=0, W15=0x00000100; feed-forward from the IV.
REQ-018 Message schedule: computed on the fly with a 16-word sliding window; standard SHA-256 constants, sigma functions, Ch, Maj; all additions mod 2^32.
REQ-019 CHECK (1 cycle): the nonce is a hit iff final digest word H7, read as unsigned 32-bit, is <= target.
REQ-020 PAD: idles DELAY_C-129 cycles so that each nonce occupies exactly DELAY_C cycles when the buffer is not full.
REQ-021 Hit handling: the miner enters WRITE and asserts nb_wr_en for exactly one cycle, in the first cycle in which nb_full is low; while nb_full is high it stalls with no write and no nonce advance.
REQ-022 Nonce sequencing: after CHECK/PAD/WRITE the nonce increments and HASH1 restarts.
REQ-023 Termination: after nonce 2^COUNTBITS-1 is handled, done pulses and the FSM returns to IDLE; there is no wrap-around.
REQ-024 Total duration with no stalls: 13 + 2^COUNTBITS*DELAY_C cycles from start to done (2077 at the defaults).
REQ-025 blk_rd_en is high only in LOAD; nb_wr_en is high only in WRITE.
REQ-026 A start pulse while busy has no effect.

Reset
REQ-027 rst_n low asynchronously forces, and holds while low: IDLE; busy=0, done=0, blk_rd_en=0, blk_rd_addr=0, nb_wr_en=0, nb_wr_data=0; nonce and hash state zeroed.
REQ-028 Reset asserted mid-search aborts the search: no further writes occur and no done pulse is produced.
REQ-029 After release the block waits in IDLE for a new start.

Verification
REQ-030 Target 0xFFFFFFFF, nb_full=0, start at cycle 0 -> 16 writes carrying nonces 0..15 in order, 129 cycles apart; done at cycle 2077.
REQ-031 Target 0x00000000 -> nb_wr_en only for nonces whose H7 is 0 according to a SHA-256 reference model, which for a typical header means no writes; done still occurs at cycle 2077.
REQ-032 Random header and target -> the set of written nonces equals that of a software double-SHA-256 model.
REQ-033 Target 0xFFFFFFFF with nb_full held high for 50 cycles at the first hit -> nonce 0 is written when nb_full drops; done is delayed by exactly 50 cycles; no write is lost or duplicated.
REQ-034 rst_n pulsed low at cycle 500 -> all outputs are 0 immediately; no done; a new start after release produces the full nonce sequence.
REQ-035 Second start during busy -> ignored; nonce sequence and done timing unchanged.
